// File: rtl/pwm_ramp_sequencer_if.sv
// Command bus into the PWM ramp sequencer: valid/ready handshake carrying a
// target duty and a step rate.
interface pwm_ramp_sequencer_if #(
   parameter int DW = 8,
   parameter int RW = 8
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [DW-1:0] cmd_target;
   logic [RW-1:0] cmd_rate;

   modport master (
      output cmd_valid,
      output cmd_target,
      output cmd_rate,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_target,
      input  cmd_rate,
      output cmd_ready
   );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Queues ramp commands and slews the PWM duty one LSB per (rate+1) PWM periods,
// updating only on period boundaries so the comparator never sees a mid-period change.
module pwm_ramp_sequencer #(
   parameter int DW    = 8,
   parameter int RW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ena,
   input  logic                     period_tick,
   input  logic                     abort,
   pwm_ramp_sequencer_if.slave      cmd,
   output logic [DW-1:0]            duty_out,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RAMP = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [DW-1:0] tgt_mem  [DEPTH];
   logic [RW-1:0] rate_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [DW-1:0] tgt_r;
   logic [RW-1:0] rate_r;
   logic [RW-1:0] rc;
   logic          push;
   logic          pop;

   // Ready comes from the registered count only, so a same-cycle pop never frees a full slot.
   assign cmd.cmd_ready = (fifo_count != FULL_COUNT) && !abort;
   assign push          = cmd.cmd_valid && cmd.cmd_ready;
   assign pop           = !abort && ena && (state == IDLE) && (fifo_count != '0);

   assign busy = (state == RAMP) || (state == DONE);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (push) begin
         tgt_mem[wr_ptr]  <= cmd.cmd_target;
         rate_mem[wr_ptr] <= cmd.cmd_rate;
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (abort) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Reaching the target is checked before any tick, so a zero-distance command
   // finishes without waiting for the PWM.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state    <= IDLE;
         duty_out <= '0;
         tgt_r    <= '0;
         rate_r   <= '0;
         rc       <= '0;
      end else if (abort) begin
         state <= IDLE;
         rc    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  tgt_r  <= tgt_mem[rd_ptr];
                  rate_r <= rate_mem[rd_ptr];
                  rc     <= '0;
                  state  <= RAMP;
               end
            end
            RAMP: begin
               if (duty_out == tgt_r) begin
                  state <= DONE;
               end else if (ena && period_tick) begin
                  if (rc == rate_r) begin
                     rc <= '0;
                     if (tgt_r > duty_out) duty_out <= duty_out + DW'(1);
                     else                  duty_out <= duty_out - DW'(1);
                  end else begin
                     rc <= rc + RW'(1);
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer: expected duty steps and done targets are
// queued at push time and checked by an independent monitor.
module tb_pwm_ramp_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       period_tick;
   logic       abort;
   logic [7:0] duty_out;
   logic       busy;
   logic       done;
   logic [2:0] fifo_count;

   pwm_ramp_sequencer_if #(.DW(8), .RW(8)) cmd_if ();

   pwm_ramp_sequencer #(.DW(8), .RW(8), .DEPTH(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .period_tick (period_tick),
      .abort       (abort),
      .cmd         (cmd_if),
      .duty_out    (duty_out),
      .busy        (busy),
      .done        (done),
      .fifo_count  (fifo_count)
   );

   always #5 clk = ~clk;

   int         checks     = 0;
   int         failures   = 0;
   int         done_seen  = 0;
   int         base       = 0;
   logic [7:0] exp_duty[$];
   logic [7:0] exp_done[$];
   logic [7:0] model_duty = 8'd0;
   logic [7:0] prev_duty  = 8'd0;
   logic       prev_done  = 1'b0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: every duty change and every done pulse is matched against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         prev_duty = duty_out;
         prev_done = 1'b0;
      end else begin
         if (duty_out !== prev_duty) begin
            if (exp_duty.size() == 0) checkOutput("duty_unexpected", duty_out, prev_duty);
            else                      checkOutput("duty_step", duty_out, exp_duty.pop_front());
         end
         if (done) begin
            done_seen++;
            checkOutput("done_width", prev_done, 0);
            if (exp_done.size() == 0) checkOutput("done_unexpected", done, 0);
            else                      checkOutput("done_target", duty_out, exp_done.pop_front());
         end
         prev_duty = duty_out;
         prev_done = done;
      end
   end

   task automatic tick();
      repeat (19) @(posedge clk);
      #1 period_tick = 1'b1;
      @(posedge clk);
      #1 period_tick = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] target, input logic [7:0] rate);
      int waited = 0;
      @(posedge clk);
      #1;
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_target = target;
      cmd_if.cmd_rate   = rate;
      forever begin
         @(negedge clk);
         if (cmd_if.cmd_ready) break;
         waited++;
         if (waited > 50) begin
            checks++;
            failures++;
            $display("[TB] FAIL push_timeout: ready never seen for target %0d", target);
            cmd_if.cmd_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1 cmd_if.cmd_valid = 1'b0;
      while (model_duty != target) begin
         model_duty = (target > model_duty) ? model_duty + 8'd1 : model_duty - 8'd1;
         exp_duty.push_back(model_duty);
      end
      exp_done.push_back(target);
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      @(negedge clk);
      while (busy || fifo_count != 3'd0) begin
         if (n == budget) begin
            checks++;
            failures++;
            $display("[TB] FAIL idle_timeout: busy=%0d count=%0d, required idle", busy, fifo_count);
            return;
         end
         tick();
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n             = 1'b1;
      ena               = 1'b0;
      period_tick       = 1'b0;
      abort             = 1'b0;
      cmd_if.cmd_valid  = 1'b0;
      cmd_if.cmd_target = 8'd0;
      cmd_if.cmd_rate   = 8'd0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      checkOutput("reset_duty", duty_out, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_ready", cmd_if.cmd_ready, 1);
      checkOutput("reset_count", fifo_count, 0);

      // Basic ramp 0 -> 3 at rate 0.
      ena  = 1'b1;
      base = done_seen;
      applyStimulus(8'd3, 8'd0);
      @(negedge clk);
      checkOutput("push_count", fifo_count, 1);
      @(negedge clk);
      checkOutput("pop_busy", busy, 1);
      repeat (3) tick();
      waitIdle(10);
      checkOutput("a_duty", duty_out, 3);
      checkOutput("a_done_count", done_seen - base, 1);
      checkOutput("a_count", fifo_count, 0);

      // Rate 2 from duty 0: first step on the third tick, target after fifteen.
      applyStimulus(8'd0, 8'd0);
      waitIdle(10);
      applyStimulus(8'd5, 8'd2);
      tick();
      tick();
      @(negedge clk);
      checkOutput("rate_tick2", duty_out, 0);
      tick();
      @(negedge clk);
      checkOutput("rate_tick3", duty_out, 1);
      repeat (11) tick();
      @(negedge clk);
      checkOutput("rate_tick14", duty_out, 4);
      tick();
      @(negedge clk);
      checkOutput("rate_tick15", duty_out, 5);
      waitIdle(5);

      // Fill the FIFO with sequencing frozen, then try a fifth command.
      ena  = 1'b0;
      base = done_seen;
      applyStimulus(8'd7, 8'd0);
      applyStimulus(8'd6, 8'd0);
      applyStimulus(8'd8, 8'd1);
      applyStimulus(8'd8, 8'd0);
      @(negedge clk);
      checkOutput("full_count", fifo_count, 4);
      checkOutput("full_ready", cmd_if.cmd_ready, 0);
      @(posedge clk);
      #1;
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_target = 8'd200;
      repeat (3) @(posedge clk);
      #1 cmd_if.cmd_valid = 1'b0;
      @(negedge clk);
      checkOutput("full_drop_count", fifo_count, 4);
      ena = 1'b1;
      waitIdle(30);
      checkOutput("c_done_count", done_seen - base, 4);
      checkOutput("c_duty", duty_out, 8);

      // Downward ramp stops at its target; equal target finishes without a tick.
      applyStimulus(8'd10, 8'd0);
      waitIdle(10);
      applyStimulus(8'd2, 8'd0);
      waitIdle(20);
      tick();
      tick();
      @(negedge clk);
      checkOutput("no_underflow", duty_out, 2);
      base = done_seen;
      applyStimulus(8'd2, 8'd5);
      repeat (3) @(negedge clk);
      #1;
      checkOutput("no_tick_done", done_seen - base, 1);
      @(negedge clk);
      checkOutput("no_tick_idle", busy, 0);

      // Abort mid-ramp with two queued and a simultaneous push.
      applyStimulus(8'd9, 8'd0);
      tick();
      tick();
      @(negedge clk);
      checkOutput("pre_abort_duty", duty_out, 4);
      applyStimulus(8'd1, 8'd0);
      applyStimulus(8'd6, 8'd0);
      @(negedge clk);
      checkOutput("pre_abort_count", fifo_count, 2);
      base = done_seen;
      @(posedge clk);
      #1;
      abort             = 1'b1;
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_target = 8'd77;
      @(negedge clk);
      checkOutput("abort_ready", cmd_if.cmd_ready, 0);
      @(posedge clk);
      #1;
      abort            = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      exp_duty.delete();
      exp_done.delete();
      model_duty = 8'd4;
      @(negedge clk);
      checkOutput("abort_count", fifo_count, 0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_duty", duty_out, 4);
      tick();
      @(negedge clk);
      #1;
      checkOutput("abort_hold_duty", duty_out, 4);
      checkOutput("abort_no_done", done_seen - base, 0);

      // Enable low mid-ramp freezes the duty across five ticks.
      applyStimulus(8'd8, 8'd0);
      tick();
      @(negedge clk);
      checkOutput("freeze_start", duty_out, 5);
      ena = 1'b0;
      repeat (5) tick();
      @(negedge clk);
      checkOutput("freeze_duty", duty_out, 5);
      checkOutput("freeze_busy", busy, 1);
      ena = 1'b1;
      waitIdle(10);
      checkOutput("resume_duty", duty_out, 8);
      checkOutput("sb_duty_empty", exp_duty.size(), 0);
      checkOutput("sb_done_empty", exp_done.size(), 0);

      // Asynchronous reset mid-ramp, between clock edges.
      applyStimulus(8'd12, 8'd0);
      tick();
      @(negedge clk);
      checkOutput("pre_reset_duty", duty_out, 9);
      @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      checkOutput("async_duty", duty_out, 0);
      checkOutput("async_busy", busy, 0);
      checkOutput("async_ready", cmd_if.cmd_ready, 1);
      checkOutput("async_count", fifo_count, 0);
      exp_duty.delete();
      exp_done.delete();
      model_duty = 8'd0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      tick();
      @(negedge clk);
      checkOutput("post_reset_duty", duty_out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/pwm_ramp_sequencer.md
# pwm_ramp_sequencer

Command-driven duty-cycle controller for the 8-bit PWM generator. It queues ramp commands (target duty plus step rate) in a 4-entry FIFO and executes them one at a time. During execution it slews its duty output one LSB at a time toward the target, and changes the output only on PWM period boundaries so the comparator never sees a mid-period duty change. It sits between the host/ui_in-side logic and the PWM comparator's duty input.

## Interface

Parameters:
- DW, 8, duty width; must match PWM duty counter width
- RW, 8, width of the per-step rate field and rate counter
- DEPTH, 4, command FIFO depth; power of two, at least 2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- ena  in  1  run enable; low freezes sequencing
- period_tick  in  1  one-cycle pulse from PWM when its duty counter wraps to 0
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept a command
- cmd_target  in  DW  target duty
- cmd_rate  in  RW  PWM periods per step, minus 1
- abort  in  1  flush FIFO, stop current ramp, hold duty
- duty_out  out  DW  duty value to PWM comparator
- busy  out  1  a command is executing (state RAMP or DONE)
- done  out  1  one-cycle pulse when a command completes
- fifo_count  out  $clog2(DEPTH)+1  commands queued

## Operation

- Reset values: duty_out=0, busy=0, done=0, cmd_ready=1, fifo_count=0, state=IDLE, rate counter rc=0.
- FIFO push happens when cmd_valid && cmd_ready && !abort.
- cmd_ready = (fifo_count != DEPTH) && !abort, computed from the registered count.
  - A pop in the same cycle does not make room for a push while the FIFO is full.
- States:
  - IDLE: if ena && fifo_count!=0, pop the head, latch tgt_r and rate_r, clear rc, go to RAMP.
  - RAMP:
    - If duty_out==tgt_r, go to DONE. This check has priority over everything below.
    - Otherwise, if ena && period_tick:
      - if rc==rate_r, step duty_out by +1 (tgt_r>duty_out) or -1 (tgt_r<duty_out) and clear rc;
      - else rc<=rc+1.
  - DONE: done=1 for this cycle, then go to IDLE.
- Arithmetic:
  - duty_out never wraps; steps are exactly ±1 and stop at tgt_r.
  - rc counts in RW bits and never exceeds rate_r.
- Duty updates occur on the clk edge where period_tick is sampled high, so the new duty is valid from the first cycle of the new PWM period.
- ena low:
  - period_tick is ignored, and rc and duty_out hold.
  - The FSM does not leave IDLE, so pushes still accepted.
  - RAMP→DONE still occurs if duty_out already equals tgt_r.
- abort:
  - Synchronous, takes precedence over push, pop and step in the same cycle.
  - Clears the FIFO (count=0) and rc, and forces state IDLE.
  - duty_out holds its current value. No done pulse is issued.
- Simultaneous push and pop (count not full) leaves fifo_count unchanged.
- A command whose target equals the current duty completes without waiting for a period_tick.
- A reset asserted mid-ramp returns all outputs to reset values immediately (asynchronous).

## Timing

- Push accepted at edge N: fifo_count increments at N.
- If IDLE and ena, pop at edge N+1: state=RAMP and busy=1 from N+1.
- Ramp duration for distance D = |tgt − duty| and rate R: D·(R+1) sampled period_ticks.
  - The first step is on the (R+1)th tick after entering RAMP.
- Final step at edge M: DONE at M+1, done high during the cycle after M+1, IDLE at M+2.
- Back-to-back commands:
  - The next pop occurs on the edge after returning to IDLE.
  - This gives a minimum 3-cycle gap between completing one command and RAMP of the next.
- done is a single-cycle pulse.
- busy covers RAMP and DONE.

## Test plan

- Reset, then push {target=3, rate=0}, pulse period_tick every 20 clk → duty_out goes 1,2,3 on successive ticks; one done pulse; busy drops; fifo_count=0.
- Push {target=5, rate=2} from duty 0 → first step on the 3rd tick; duty_out=5 after exactly 15 ticks; no change between ticks.
- Push 4 commands with no ticks and ena=0, then attempt a 5th → cmd_ready=0 and fifo_count=4, 5th not stored. Raise ena → commands execute in order with 4 done pulses.
- Ramp 10→2 with rate=0 → duty decrements one per tick and stops at 2, no underflow. Then push target=2 → done within 3 clk with no tick needed.
- Mid-ramp at duty=4 toward 9 with 2 queued: assert abort together with cmd_valid → FIFO empty, push dropped, duty_out stays 4, no done pulse. Separately, deassert ena mid-ramp for 5 ticks → duty frozen, resumes after ena returns.
- Assert rst_n mid-ramp between clock edges → duty_out=0, busy=0, cmd_ready=1 immediately, before the next clk edge.
